hpi_xfer_engine: RTL and testbench



---
 rtl/hpi_xfer_engine.sv | 203 ++++++++++++++++++++
 tb/tb_hpi_xfer_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_xfer_engine.sv
// HPI bus master: queues read/write/chip-reset commands and plays them out on the
// OTG host port interface with programmable setup/strobe/hold/reset timing.
module hpi_xfer_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RESET_CYC  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] hpi_addr,
  output logic [DATA_W-1:0] hpi_data_out,
  output logic              hpi_data_oe,
  input  logic [DATA_W-1:0] hpi_data_in,
  output logic              hpi_cs_n,
  output logic              hpi_r_n,
  output logic              hpi_w_n,
  output logic              hpi_rst_n
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HR = (HOLD_CYC > RESET_CYC) ? HOLD_CYC : RESET_CYC;
  localparam int MAX_C  = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  // Reload values are "cycles - 1": the counter runs down to zero inside the state.
  localparam int SETUP_LD  = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int STROBE_LD = STROBE_CYC - 1;
  localparam int HOLD_LD   = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
  localparam int RESET_LD  = RESET_CYC - 1;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP, RST} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [1:0]        op_mem    [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_data_q;
  logic              is_rd;

  assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign is_rd     = (op_q == OP_RD);
  assign busy      = !empty || (state != IDLE);

  always_ff @(posedge clk_clk) begin
    if (push) begin
      op_mem[wptr]    <= cmd_op;
      addr_mem[wptr]  <= cmd_addr;
      wdata_mem[wptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      if (pop) begin
        op_q    <= op_mem[rptr];
        addr_q  <= addr_mem[rptr];
        wdata_q <= wdata_mem[rptr];
      end
      if (state == STROBE && cnt == '0 && is_rd) rsp_data_q <= hpi_data_in;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        if (!empty) begin
          case (op_mem[rptr])
            OP_RD, OP_WR: begin
              if (SETUP_CYC > 0) begin
                state_nxt = SETUP;
                cnt_nxt   = CNT_W'(SETUP_LD);
              end else begin
                state_nxt = STROBE;
                cnt_nxt   = CNT_W'(STROBE_LD);
              end
            end
            OP_RST: begin
              state_nxt = RST;
              cnt_nxt   = CNT_W'(RESET_LD);
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(STROBE_LD);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (HOLD_CYC > 0) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(HOLD_LD);
          end else begin
            state_nxt = is_rd ? RESP : IDLE;
          end
        end
      end
      HOLD: if (cnt == '0) state_nxt = is_rd ? RESP : IDLE;
      RESP: if (rsp_ready) state_nxt = IDLE;
      RST:  if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hpi_cs_n    = 1'b1;
    hpi_r_n     = 1'b1;
    hpi_w_n     = 1'b1;
    hpi_rst_n   = 1'b1;
    hpi_data_oe = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      SETUP: begin
        hpi_cs_n    = 1'b0;
        hpi_data_oe = !is_rd;
      end
      STROBE: begin
        hpi_cs_n    = 1'b0;
        hpi_r_n     = !is_rd;
        hpi_w_n     = is_rd;
        hpi_data_oe = !is_rd;
      end
      HOLD: begin
        hpi_cs_n    = 1'b0;
        hpi_data_oe = !is_rd;
      end
      RESP:    rsp_valid = 1'b1;
      RST:     hpi_rst_n = 1'b0;
      default: ;
    endcase
  end

  assign hpi_addr     = addr_q;
  assign hpi_data_out = wdata_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_hpi_xfer_engine.sv
// Bench for hpi_xfer_engine: command vector table plus corner-case sequences,
// with a bus monitor scoring every HPI transaction against an expected queue.
module tb_hpi_xfer_engine;
  localparam int SETUP  = 1;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int RSTC   = 16;
  localparam int WIN    = SETUP + STROBE + HOLD;

  logic        clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        busy;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in = '0;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n;

  hpi_xfer_engine #(
    .DATA_W(16), .ADDR_W(2), .FIFO_DEPTH(4), .SETUP_CYC(SETUP),
    .STROBE_CYC(STROBE), .HOLD_CYC(HOLD), .RESET_CYC(RSTC)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out),
    .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_rst_n(hpi_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] data;
  } bus_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  bus_t        exp_bus[$];
  logic [15:0] exp_rsp[$];
  int          checks = 0;
  int          errors = 0;
  int          viol = 0;
  bit          abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Bus monitor: measures each cs_n-low window and scores it on cs_n release.
  int          win = 0, w_first = 0, w_cnt = 0, r_first = 0, r_cnt = 0, oe_cyc = 0;
  logic [1:0]  m_addr;
  logic [15:0] m_data;
  bit          m_chg;

  always @(negedge clk) begin
    if (reset_reset || abort) begin
      win = 0; w_first = 0; w_cnt = 0; r_first = 0; r_cnt = 0; oe_cyc = 0;
    end else begin
      if ((!hpi_r_n && !hpi_w_n) || ((!hpi_r_n || !hpi_w_n) && hpi_cs_n) ||
          (hpi_data_oe && !hpi_r_n) || (!hpi_rst_n && !hpi_cs_n))
        viol++;
      if (hpi_cs_n === 1'b0) begin
        win++;
        if (win == 1) begin
          m_addr = hpi_addr;
          m_data = hpi_data_out;
          m_chg  = 1'b0;
        end else if (hpi_addr !== m_addr || (hpi_data_oe && hpi_data_out !== m_data)) begin
          m_chg = 1'b1;
        end
        if (!hpi_w_n) begin
          if (w_cnt == 0) w_first = win;
          w_cnt++;
        end
        if (!hpi_r_n) begin
          if (r_cnt == 0) r_first = win;
          r_cnt++;
        end
        if (hpi_data_oe) oe_cyc++;
      end else if (win > 0) begin
        if (exp_bus.size() == 0) begin
          fail("bus_unexpected_xfer");
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          check("bus_addr", 32'(m_addr), 32'(e.addr));
          check("bus_cs_len", win, WIN);
          check("bus_stable", 32'(m_chg), 0);
          check("strobe_start", e.wr ? w_first : r_first, SETUP + 1);
          check("strobe_len", e.wr ? w_cnt : r_cnt, STROBE);
          check("other_strobe", e.wr ? r_cnt : w_cnt, 0);
          check("oe_cycles", oe_cyc, e.wr ? WIN : 0);
          if (e.wr) check("bus_wdata", 32'(m_data), 32'(e.data));
        end
        win = 0; w_first = 0; w_cnt = 0; r_first = 0; r_cnt = 0; oe_cyc = 0;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] addr,
                          input logic [15:0] wd, input logic [15:0] rd, input bit track);
    int n = 0;
    if (op == 2'b00) hpi_data_in = rd;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("cmd_ready_timeout");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    if (track && !op[1]) exp_bus.push_back('{wr: op[0], addr: addr, data: wd});
    if (track && op == 2'b00) exp_rsp.push_back(rd);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail("rsp_valid_timeout");
  endtask

  task automatic get_rsp();
    wait_rsp_valid();
    if (!rsp_valid) return;
    if (exp_rsp.size() == 0) fail("rsp_unexpected");
    else check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("idle_timeout");
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int n, len, bad;
    vecs[0] = '{op: 2'b01, addr: 2'd2, wdata: 16'h1234, rdata: 16'h0000};
    vecs[1] = '{op: 2'b00, addr: 2'd0, wdata: 16'h0000, rdata: 16'hBEEF};
    vecs[2] = '{op: 2'b01, addr: 2'd1, wdata: 16'hA5A5, rdata: 16'h0000};
    vecs[3] = '{op: 2'b00, addr: 2'd3, wdata: 16'h0000, rdata: 16'h0F0F};
    vecs[4] = '{op: 2'b11, addr: 2'd1, wdata: 16'hDEAD, rdata: 16'h0000};
    vecs[5] = '{op: 2'b01, addr: 2'd3, wdata: 16'hFFFF, rdata: 16'h0000};
    vecs[6] = '{op: 2'b00, addr: 2'd1, wdata: 16'h0000, rdata: 16'h0000};

    repeat (3) @(negedge clk);
    reset_reset = 1'b0;

    // Reset defaults held over ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      check("reset_defaults", {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, hpi_data_oe,
                               cmd_ready, busy, rsp_valid}, 8'b1111_0100);
      @(negedge clk);
    end
    check("reset_datapath", {hpi_addr, hpi_data_out, rsp_data}, 34'h0);

    for (int i = 0; i < 7; i++) begin
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b1);
      if (vecs[i].op == 2'b00) get_rsp();
      wait_idle();
      check("sb_drained", exp_bus.size(), 0);
    end

    // Response back-pressure: queued write must wait for the response handshake.
    send_cmd(2'b00, 2'd0, 16'h0000, 16'hBEEF, 1'b1);
    send_cmd(2'b01, 2'd1, 16'h5555, 16'h0000, 1'b1);
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      check("rsp_hold_valid", 32'(rsp_valid), 1);
      check("rsp_hold_data", 32'(rsp_data), 32'hBEEF);
      check("queued_write_blocked", 32'(hpi_cs_n), 1);
      @(negedge clk);
    end
    get_rsp();
    wait_idle();
    check("sb_drained_bp", exp_bus.size(), 0);

    // FIFO full while the FSM sits in RESP, then five writes drain in order.
    send_cmd(2'b00, 2'd2, 16'h0000, 16'h7777, 1'b1);
    wait_rsp_valid();
    for (int k = 1; k <= 4; k++) send_cmd(2'b01, 2'(k), 16'(k), 16'h0000, 1'b1);
    check("fifo_full_ready", 32'(cmd_ready), 0);
    check("fifo_full_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    check("fifo_full_ready_hold", 32'(cmd_ready), 0);
    get_rsp();
    send_cmd(2'b01, 2'd1, 16'h0005, 16'h0000, 1'b1);
    wait_idle();
    check("sb_drained_fifo", exp_bus.size(), 0);

    // Chip reset pulse width and quiet bus.
    send_cmd(2'b10, 2'd0, 16'h0000, 16'h0000, 1'b1);
    n = 0;
    while (hpi_rst_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hpi_rst_n) fail("chip_reset_start_timeout");
    len = 0;
    bad = 0;
    while (!hpi_rst_n && len < 100) begin
      if (!hpi_cs_n || !hpi_r_n || !hpi_w_n || !busy) bad++;
      len++;
      @(negedge clk);
    end
    check("chip_reset_len", len, RSTC);
    check("chip_reset_quiet", bad, 0);
    wait_idle();

    // Synchronous reset in the middle of a write strobe with commands queued.
    send_cmd(2'b01, 2'd3, 16'hCAFE, 16'h0000, 1'b0);
    send_cmd(2'b01, 2'd2, 16'h1111, 16'h0000, 1'b0);
    send_cmd(2'b00, 2'd1, 16'h0000, 16'h2222, 1'b0);
    n = 0;
    while (hpi_w_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hpi_w_n) fail("mid_strobe_timeout");
    abort = 1'b1;
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;
    check("mid_reset_outputs", {hpi_w_n, hpi_r_n, hpi_cs_n, hpi_data_oe, cmd_ready, busy,
                                hpi_rst_n, rsp_valid}, 8'b1110_1010);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!hpi_cs_n || busy || !hpi_rst_n) bad++;
    end
    check("no_issue_after_reset", bad, 0);
    abort = 1'b0;

    check("bus_rules", viol, 0);
    check("sb_final", exp_bus.size() + exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
